bip_datapath: RTL and testbench

- Execution datapath of the BIP1 single-cycle processor, directly downstream of the control unit.
- Consumes the operand and decoded strobes (SelA, SelB, WrAcc, op, WrRam, RdRam) produced each cycle by control.
- Holds the accumulator, the sign-extension unit, the add/sub ALU, the data RAM and registered status flags.
- A debug read port gives the bench and the top level access to RAM.

---
 rtl/bip_datapath.sv | 58 +++++
 tb/tb_bip_datapath.sv | 113 +++++++++++
 2 files changed

// File: rtl/bip_datapath.sv
// bip_datapath: BIP1 execution datapath with accumulator, add/sub ALU, data RAM and status flags.
module bip_datapath #(
  parameter int NB_DATA    = 16,
  parameter int NB_OPERAND = 11,
  parameter int RAM_DEPTH  = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NB_OPERAND-1:0] i_operand,
  input  logic [1:0]            i_SelA,
  input  logic                  i_SelB,
  input  logic                  i_WrAcc,
  input  logic                  i_op,
  input  logic                  i_WrRam,
  input  logic                  i_RdRam,
  input  logic [NB_OPERAND-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0]    o_acc,
  output logic                  o_zero,
  output logic                  o_neg,
  output logic                  o_ovf,
  output logic [NB_DATA-1:0]    o_dbg_data
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam logic [NB_OPERAND:0] DEPTH = (NB_OPERAND+1)'(RAM_DEPTH);
  logic [NB_DATA-1:0] ram [RAM_DEPTH];
  logic               op_in_range, dbg_in_range, wr_acc, alu_ovf;
  logic [NB_DATA-1:0] ext, rd_data, alu_b, alu_res, acc_next;
  always_comb begin
    op_in_range  = {1'b0, i_operand} < DEPTH;
    dbg_in_range = {1'b0, i_dbg_addr} < DEPTH;
    ext          = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}}, i_operand};
    rd_data      = (i_RdRam && op_in_range) ? ram[i_operand[AW-1:0]] : '0;
    o_dbg_data   = dbg_in_range ? ram[i_dbg_addr[AW-1:0]] : '0;
    alu_b        = i_SelB ? ext : rd_data;
    alu_res      = i_op ? o_acc - alu_b : o_acc + alu_b;
    // sub overflows when operand signs differ, add when they match; both need a result sign flip
    alu_ovf      = ((o_acc[NB_DATA-1] ^ alu_b[NB_DATA-1]) == i_op) &&
                   (alu_res[NB_DATA-1] != o_acc[NB_DATA-1]);
    acc_next     = i_SelA == 2'b00 ? rd_data : i_SelA == 2'b01 ? ext : alu_res;
    wr_acc       = i_WrAcc && i_SelA != 2'b11;
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_acc  <= '0;
      o_zero <= 1'b1;
      o_neg  <= 1'b0;
      o_ovf  <= 1'b0;
    end else if (wr_acc) begin
      o_acc  <= acc_next;
      o_zero <= acc_next == '0;
      o_neg  <= acc_next[NB_DATA-1];
      o_ovf  <= i_SelA == 2'b10 && alu_ovf;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_WrRam && op_in_range) ram[i_operand[AW-1:0]] <= o_acc;
  end
endmodule

// File: tb/tb_bip_datapath.sv
// tb_bip_datapath: directed vectors with a queue-based scoreboard and an edge-driven monitor.
module tb_bip_datapath;
  logic        i_clk = 1'b0, i_rst = 1'b0;
  logic [10:0] i_operand = '0, i_dbg_addr = '0;
  logic [1:0]  i_SelA = '0;
  logic        i_SelB = 1'b0, i_WrAcc = 1'b0, i_op = 1'b0, i_WrRam = 1'b0, i_RdRam = 1'b0;
  logic [15:0] o_acc, o_dbg_data;
  logic        o_zero, o_neg, o_ovf;
  int          errors = 0, checks = 0;
  typedef struct {
    logic [15:0] acc;
    logic        z, n, o, cd;
    logic [15:0] dbg;
    string       name;
  } exp_t;
  exp_t q[$];
  bip_datapath dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_operand(i_operand), .i_SelA(i_SelA), .i_SelB(i_SelB),
    .i_WrAcc(i_WrAcc), .i_op(i_op), .i_WrRam(i_WrRam), .i_RdRam(i_RdRam), .i_dbg_addr(i_dbg_addr),
    .o_acc(o_acc), .o_zero(o_zero), .o_neg(o_neg), .o_ovf(o_ovf), .o_dbg_data(o_dbg_data)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step(input string nm, input logic [1:0] sa, input logic sb, wa, op, wr, rd,
                      input logic [10:0] opd, da, input logic [15:0] eacc,
                      input logic ez, en, eo, cd, input logic [15:0] edbg);
    @(negedge i_clk);
    i_SelA = sa; i_SelB = sb; i_WrAcc = wa; i_op = op; i_WrRam = wr; i_RdRam = rd;
    i_operand = opd; i_dbg_addr = da;
    q.push_back('{acc: eacc, z: ez, n: en, o: eo, cd: cd, dbg: edbg, name: nm});
  endtask
  initial forever begin
    exp_t e;
    @(posedge i_clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.name, " acc"}, o_acc, e.acc);
      chk({e.name, " zero"}, 16'(o_zero), 16'(e.z));
      chk({e.name, " neg"}, 16'(o_neg), 16'(e.n));
      chk({e.name, " ovf"}, 16'(o_ovf), 16'(e.o));
      if (e.cd) chk({e.name, " dbg"}, o_dbg_data, e.dbg);
    end
  end
  initial begin
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    step("ldi5",     2'd1, 0, 1, 0, 0, 0, 11'h005, 11'h0,   16'h0005, 0, 0, 0, 0, 16'h0);
    @(posedge i_clk);
    #3;
    i_rst = 1'b0;
    i_WrAcc = 1'b0; i_SelA = 2'd0;
    #1;
    chk("async_rst acc", o_acc, 16'h0000);
    chk("async_rst zero", 16'(o_zero), 16'd1);
    chk("async_rst neg", 16'(o_neg), 16'd0);
    chk("async_rst ovf", 16'(o_ovf), 16'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    step("ldi7ff",   2'd1, 0, 1, 0, 0, 0, 11'h7FF, 11'h0,   16'hFFFF, 0, 1, 0, 0, 16'h0);
    step("addi1",    2'd2, 1, 1, 0, 0, 0, 11'h001, 11'h0,   16'h0000, 1, 0, 0, 0, 16'h0);
    step("ldi123",   2'd1, 0, 1, 0, 0, 0, 11'h123, 11'h0,   16'h0123, 0, 0, 0, 0, 16'h0);
    step("sto0a",    2'd0, 0, 0, 0, 1, 0, 11'h000, 11'h0,   16'h0123, 0, 0, 0, 1, 16'h0123);
    step("add0a",    2'd2, 0, 1, 0, 0, 1, 11'h000, 11'h0,   16'h0246, 0, 0, 0, 0, 16'h0);
    step("sto0b",    2'd0, 0, 0, 0, 1, 0, 11'h000, 11'h0,   16'h0246, 0, 0, 0, 1, 16'h0246);
    step("add0b",    2'd2, 0, 1, 0, 0, 1, 11'h000, 11'h0,   16'h048C, 0, 0, 0, 0, 16'h0);
    step("sto0c",    2'd0, 0, 0, 0, 1, 0, 11'h000, 11'h0,   16'h048C, 0, 0, 0, 1, 16'h048C);
    step("add0c",    2'd2, 0, 1, 0, 0, 1, 11'h000, 11'h0,   16'h0918, 0, 0, 0, 0, 16'h0);
    step("sto0d",    2'd0, 0, 0, 0, 1, 0, 11'h000, 11'h0,   16'h0918, 0, 0, 0, 1, 16'h0918);
    step("add0d",    2'd2, 0, 1, 0, 0, 1, 11'h000, 11'h0,   16'h1230, 0, 0, 0, 0, 16'h0);
    step("addi4",    2'd2, 1, 1, 0, 0, 0, 11'h004, 11'h0,   16'h1234, 0, 0, 0, 0, 16'h0);
    step("sto3",     2'd0, 0, 0, 0, 1, 0, 11'h003, 11'h003, 16'h1234, 0, 0, 0, 1, 16'h1234);
    step("ldi0a",    2'd1, 0, 1, 0, 0, 0, 11'h000, 11'h0,   16'h0000, 1, 0, 0, 0, 16'h0);
    step("ld3",      2'd0, 0, 1, 0, 0, 1, 11'h003, 11'h0,   16'h1234, 0, 0, 0, 0, 16'h0);
    step("ld3_nord", 2'd0, 0, 1, 0, 0, 0, 11'h003, 11'h0,   16'h0000, 1, 0, 0, 0, 16'h0);
    step("ldi1",     2'd1, 0, 1, 0, 0, 0, 11'h001, 11'h0,   16'h0001, 0, 0, 0, 0, 16'h0);
    step("sto5",     2'd0, 0, 0, 0, 1, 0, 11'h005, 11'h005, 16'h0001, 0, 0, 0, 1, 16'h0001);
    step("ldi400",   2'd1, 0, 1, 0, 0, 0, 11'h400, 11'h0,   16'hFC00, 0, 1, 0, 0, 16'h0);
    step("dsto1",    2'd0, 0, 0, 0, 1, 0, 11'h000, 11'h0,   16'hFC00, 0, 1, 0, 1, 16'hFC00);
    step("dadd1",    2'd2, 0, 1, 0, 0, 1, 11'h000, 11'h0,   16'hF800, 0, 1, 0, 0, 16'h0);
    step("dsto2",    2'd0, 0, 0, 0, 1, 0, 11'h000, 11'h0,   16'hF800, 0, 1, 0, 1, 16'hF800);
    step("dadd2",    2'd2, 0, 1, 0, 0, 1, 11'h000, 11'h0,   16'hF000, 0, 1, 0, 0, 16'h0);
    step("dsto3",    2'd0, 0, 0, 0, 1, 0, 11'h000, 11'h0,   16'hF000, 0, 1, 0, 1, 16'hF000);
    step("dadd3",    2'd2, 0, 1, 0, 0, 1, 11'h000, 11'h0,   16'hE000, 0, 1, 0, 0, 16'h0);
    step("dsto4",    2'd0, 0, 0, 0, 1, 0, 11'h000, 11'h0,   16'hE000, 0, 1, 0, 1, 16'hE000);
    step("dadd4",    2'd2, 0, 1, 0, 0, 1, 11'h000, 11'h0,   16'hC000, 0, 1, 0, 0, 16'h0);
    step("dsto5",    2'd0, 0, 0, 0, 1, 0, 11'h000, 11'h0,   16'hC000, 0, 1, 0, 1, 16'hC000);
    step("dadd5",    2'd2, 0, 1, 0, 0, 1, 11'h000, 11'h0,   16'h8000, 0, 1, 0, 0, 16'h0);
    step("subi1a",   2'd2, 1, 1, 1, 0, 0, 11'h001, 11'h0,   16'h7FFF, 0, 0, 1, 0, 16'h0);
    step("add5_ovf", 2'd2, 0, 1, 0, 0, 1, 11'h005, 11'h0,   16'h8000, 0, 1, 1, 0, 16'h0);
    step("subi1b",   2'd2, 1, 1, 1, 0, 0, 11'h001, 11'h0,   16'h7FFF, 0, 0, 1, 0, 16'h0);
    step("sela11",   2'd3, 0, 1, 0, 0, 1, 11'h005, 11'h0,   16'h7FFF, 0, 0, 1, 0, 16'h0);
    step("ldi0b",    2'd1, 0, 1, 0, 0, 0, 11'h000, 11'h0,   16'h0000, 1, 0, 0, 0, 16'h0);
    step("ldi2a",    2'd1, 0, 1, 0, 0, 0, 11'h02A, 11'h0,   16'h002A, 0, 0, 0, 0, 16'h0);
    step("sto1023",  2'd0, 0, 0, 0, 1, 0, 11'h3FF, 11'h3FF, 16'h002A, 0, 0, 0, 1, 16'h002A);
    step("sto1024",  2'd0, 0, 0, 0, 1, 0, 11'h400, 11'h400, 16'h002A, 0, 0, 0, 1, 16'h0000);
    step("ld1024",   2'd0, 0, 1, 0, 0, 1, 11'h400, 11'h3FF, 16'h0000, 1, 0, 0, 1, 16'h002A);
    step("ldiaa",    2'd1, 0, 1, 0, 0, 0, 11'h0AA, 11'h0,   16'h00AA, 0, 0, 0, 0, 16'h0);
    step("simul",    2'd1, 0, 1, 0, 1, 0, 11'h055, 11'h055, 16'h0055, 0, 0, 0, 1, 16'h00AA);
    step("hlt",      2'd0, 0, 0, 0, 0, 0, 11'h000, 11'h055, 16'h0055, 0, 0, 0, 1, 16'h00AA);
    step("hlt2",     2'd0, 0, 0, 0, 0, 0, 11'h000, 11'h003, 16'h0055, 0, 0, 0, 1, 16'h1234);
    repeat (3) @(negedge i_clk);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
